// File: rtl/fetch_ras.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fetch_ras : return address stack for the fetch predictor (push/pop/restore)
// Rev 1.0
// ----------------------------------------------------------------------------
module fetch_ras #(
    parameter int RAS_ENTRIES     = 16,
    parameter int LOG_RAS_ENTRIES = 4
) (
    input  logic                       CLK,
    input  logic                       nRST,
    input  logic                       link_valid,
    input  logic [37:0]                link_pc38,
    input  logic                       ret_valid,
    output logic [37:0]                ret_pc38,
    output logic                       ret_empty,
    output logic [LOG_RAS_ENTRIES-1:0] ras_index,
    output logic [LOG_RAS_ENTRIES:0]   ras_count,
    input  logic                       restore_valid,
    input  logic [LOG_RAS_ENTRIES-1:0] restore_ras_index,
    input  logic [LOG_RAS_ENTRIES:0]   restore_ras_count
);

    typedef logic [37:0]                pc38_t;
    typedef logic [LOG_RAS_ENTRIES-1:0] ras_idx_t;
    typedef logic [LOG_RAS_ENTRIES:0]   ras_count_t;

    localparam ras_count_t C_FULL = ras_count_t'(RAS_ENTRIES);

    pc38_t      ras_q [RAS_ENTRIES];
    pc38_t      ras_d [RAS_ENTRIES];
    ras_idx_t   ptr_q, ptr_d;
    ras_count_t count_q, count_d;

    always_comb begin
        ras_d   = ras_q;
        ptr_d   = ptr_q;
        count_d = count_q;
        if (restore_valid) begin
            // Out-of-range restore counts are clamped rather than trusted.
            ptr_d   = restore_ras_index;
            count_d = (restore_ras_count > C_FULL) ? C_FULL : restore_ras_count;
        end else if (link_valid && ret_valid) begin
            ras_d[ptr_q] = link_pc38;
            count_d      = (count_q == '0) ? ras_count_t'(1) : count_q;
        end else if (link_valid) begin
            ptr_d        = ptr_q + 1'b1;
            ras_d[ptr_d] = link_pc38;
            count_d      = (count_q == C_FULL) ? C_FULL : count_q + 1'b1;
        end else if (ret_valid) begin
            // Pointer moves even when empty to stay aligned with checkpoints.
            ptr_d   = ptr_q - 1'b1;
            count_d = (count_q == '0) ? '0 : count_q - 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < RAS_ENTRIES; i++) begin
                ras_q[i] <= '0;
            end
            ptr_q   <= '0;
            count_q <= '0;
        end else begin
            ras_q   <= ras_d;
            ptr_q   <= ptr_d;
            count_q <= count_d;
        end
    end

    assign ret_pc38  = ras_q[ptr_q];
    assign ret_empty = (count_q == '0);
    assign ras_index = ptr_q;
    assign ras_count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_ras.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_fetch_ras : scoreboard bench for fetch_ras against a behavioural model
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_fetch_ras;

    localparam int N = 16;
    localparam int L = 4;

    logic          CLK = 1'b0;
    logic          nRST = 1'b0;
    logic          link_valid = 1'b0;
    logic [37:0]   link_pc38 = '0;
    logic          ret_valid = 1'b0;
    logic [37:0]   ret_pc38;
    logic          ret_empty;
    logic [L-1:0]  ras_index;
    logic [L:0]    ras_count;
    logic          restore_valid = 1'b0;
    logic [L-1:0]  restore_ras_index = '0;
    logic [L:0]    restore_ras_count = '0;

    fetch_ras #(.RAS_ENTRIES(N), .LOG_RAS_ENTRIES(L)) dut (
        .CLK               (CLK),
        .nRST              (nRST),
        .link_valid        (link_valid),
        .link_pc38         (link_pc38),
        .ret_valid         (ret_valid),
        .ret_pc38          (ret_pc38),
        .ret_empty         (ret_empty),
        .ras_index         (ras_index),
        .ras_count         (ras_count),
        .restore_valid     (restore_valid),
        .restore_ras_index (restore_ras_index),
        .restore_ras_count (restore_ras_count)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [37:0]  pc;
        logic         empty;
        logic [L-1:0] idx;
        logic [L:0]   cnt;
    } exp_t;

    exp_t         sb [$];
    logic [37:0]  m_arr [N];
    logic [L-1:0] m_ptr;
    logic [L:0]   m_cnt;
    logic [37:0]  pre_pc;
    logic [L-1:0] pre_idx;
    logic [L:0]   pre_cnt;
    int           n_tests = 0;
    int           n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_arr[i] = '0;
        m_ptr = '0;
        m_cnt = '0;
    endtask

    function automatic exp_t model_out();
        exp_t e;
        e.pc    = m_arr[m_ptr];
        e.empty = (m_cnt == 0);
        e.idx   = m_ptr;
        e.cnt   = m_cnt;
        return e;
    endfunction

    task automatic check_outputs(input string tag, input exp_t e);
        check({tag, ".pc"},    64'(ret_pc38),  64'(e.pc));
        check({tag, ".empty"}, 64'(ret_empty), 64'(e.empty));
        check({tag, ".idx"},   64'(ras_index), 64'(e.idx));
        check({tag, ".cnt"},   64'(ras_count), 64'(e.cnt));
    endtask

    // One clock of stimulus: same-cycle outputs checked before the edge,
    // the model's next state queued and compared after it.
    task automatic step(input logic lv, input logic [37:0] lpc, input logic rv,
                        input logic rsv, input logic [L-1:0] ri, input logic [L:0] rc);
        exp_t e;
        @(negedge CLK);
        link_valid        = lv;
        link_pc38         = lpc;
        ret_valid         = rv;
        restore_valid     = rsv;
        restore_ras_index = ri;
        restore_ras_count = rc;
        #1;
        assert (!rsv || rc <= N) else $error("illegal restore count %0d", rc);
        pre_pc  = ret_pc38;
        pre_idx = ras_index;
        pre_cnt = ras_count;
        check_outputs("pre", model_out());
        if (rsv) begin
            m_ptr = ri;
            m_cnt = (rc > N) ? (L+1)'(N) : rc;
        end else if (lv && rv) begin
            m_arr[m_ptr] = lpc;
            if (m_cnt == 0) m_cnt = 1;
        end else if (lv) begin
            m_ptr        = m_ptr + 1'b1;
            m_arr[m_ptr] = lpc;
            if (m_cnt < N) m_cnt = m_cnt + 1'b1;
        end else if (rv) begin
            m_ptr = m_ptr - 1'b1;
            if (m_cnt != 0) m_cnt = m_cnt - 1'b1;
        end
        sb.push_back(model_out());
        @(posedge CLK);
        #1;
        if (sb.size() == 0) begin
            check("sb_underflow", 64'd1, 64'd0);
        end else begin
            e = sb.pop_front();
            check_outputs("post", e);
        end
        link_valid    = 1'b0;
        ret_valid     = 1'b0;
        restore_valid = 1'b0;
    endtask

    task automatic push(input logic [37:0] pc);  step(1'b1, pc, 1'b0, 1'b0, '0, '0); endtask
    task automatic pop();                         step(1'b0, '0, 1'b1, 1'b0, '0, '0); endtask
    task automatic idle();                        step(1'b0, '0, 1'b0, 1'b0, '0, '0); endtask
    task automatic restore(input logic [L-1:0] ri, input logic [L:0] rc);
        step(1'b0, '0, 1'b0, 1'b1, ri, rc);
    endtask

    initial begin
        logic [37:0] exp_pop [3];
        exp_pop[0] = 38'h300; exp_pop[1] = 38'h200; exp_pop[2] = 38'h100;
        model_reset();
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        nRST = 1'b1;
        idle();
        idle();
        check("rst.empty", 64'(ret_empty), 64'd1);
        check("rst.idx",   64'(ras_index), 64'd0);
        check("rst.cnt",   64'(ras_count), 64'd0);
        check("rst.pc",    64'(ret_pc38),  64'd0);

        push(38'h100); push(38'h200); push(38'h300);
        for (int i = 0; i < 3; i++) begin
            pop();
            check("pop3.pc",  64'(pre_pc),  64'(exp_pop[i]));
            check("pop3.idx", 64'(pre_idx), 64'(3 - i));
            check("pop3.cnt", 64'(pre_cnt), 64'(3 - i));
        end
        check("pop3.end_cnt",   64'(ras_count), 64'd0);
        check("pop3.end_empty", 64'(ret_empty), 64'd1);

        for (int i = 1; i <= 17; i++) push(38'(i));
        check("full.cnt", 64'(ras_count), 64'd16);
        check("full.idx", 64'(ras_index), 64'd1);
        check("full.top", 64'(ret_pc38),  64'h11);
        for (int i = 0; i < 16; i++) begin
            pop();
            check("full.pop", 64'(pre_pc), 64'(17 - i));
        end
        pop();
        check("full.over_cnt",   64'(ras_count), 64'd0);
        check("full.over_empty", 64'(ret_empty), 64'd1);
        check("full.over_idx",   64'(ras_index), 64'd0);

        push(38'h100);
        step(1'b1, 38'h444, 1'b1, 1'b0, '0, '0);
        check("retl.same_pc", 64'(pre_pc),    64'h100);
        check("retl.next_pc", 64'(ret_pc38),  64'h444);
        check("retl.idx",     64'(ras_index), 64'd1);
        check("retl.cnt",     64'(ras_count), 64'd1);
        pop();
        step(1'b1, 38'h555, 1'b1, 1'b0, '0, '0);
        check("retl_empty.cnt", 64'(ras_count), 64'd1);
        check("retl_empty.pc",  64'(ret_pc38),  64'h555);

        step(1'b1, 38'hABC, 1'b0, 1'b1, 4'd5, 5'd3);
        check("rest.idx", 64'(ras_index), 64'd5);
        check("rest.cnt", 64'(ras_count), 64'd3);
        restore(4'd6, 5'd3);
        check("rest.arr6", 64'(ret_pc38), 64'h6);

        restore(4'd0, 5'd0);
        pop();
        check("pop_empty.idx",   64'(ras_index), 64'd15);
        check("pop_empty.cnt",   64'(ras_count), 64'd0);
        check("pop_empty.empty", 64'(ret_empty), 64'd1);

        for (int i = 0; i < 4; i++) push(38'h7000 + 38'(i));
        // Asynchronous reset mid-cycle with a push pending across the edge.
        @(negedge CLK);
        link_valid = 1'b1;
        link_pc38  = 38'h3FFF;
        #2 nRST = 1'b0;
        #1;
        model_reset();
        check_outputs("async_rst", model_out());
        @(posedge CLK);
        #1;
        check_outputs("rst_hold", model_out());
        @(negedge CLK);
        nRST       = 1'b1;
        link_valid = 1'b0;
        idle();
        check("rst_after.pc", 64'(ret_pc38), 64'd0);

        for (int i = 0; i < 300; i++) begin
            logic rsv;
            rsv = ($urandom_range(0, 7) == 0);
            step(1'($urandom_range(0, 1)), {6'd0, $urandom()}, 1'($urandom_range(0, 1)),
                 rsv, L'($urandom_range(0, N - 1)), (L+1)'($urandom_range(0, N)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
